// File: rtl/myiface_producer_if.sv
// myiface: a 3-bit item bus with one producer view and one consumer view.
interface myiface;
    logic [2:0] item;

    modport producer (output item);
    modport consumer (input item);
endinterface

// File: rtl/myiface_producer.sv
// Queues 3-bit values from a valid/ready port and presents each on iface.item
// for HOLD cycles, returning item to IDLE_VAL when nothing is queued.
module myiface_producer #(
    parameter int unsigned HOLD     = 2,
    parameter int unsigned DEPTH    = 4,
    parameter logic [2:0]  IDLE_VAL = 3'b000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [2:0]                 in_data,
    output logic                       in_ready,
    myiface.producer                   iface,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [3:0]    HOLD_LD  = 4'(HOLD - 1);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t          state, state_d;
    logic [3:0]      hcnt, hcnt_d;
    logic [2:0]      item_q, item_d;
    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;
    logic            push, pop, nonempty;

    // Ready is a function of occupancy only, so a same-cycle pop never frees a slot early.
    assign in_ready = (cnt < FULL) && rst_n;
    assign push     = in_valid && in_ready;
    assign nonempty = (cnt != '0);

    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        item_d  = item_q;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                item_d = IDLE_VAL;
                if (nonempty) begin
                    pop     = 1'b1;
                    item_d  = mem[rptr];
                    hcnt_d  = HOLD_LD;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hcnt != '0) begin
                    hcnt_d = hcnt - 4'd1;
                end else if (nonempty) begin
                    pop    = 1'b1;
                    item_d = mem[rptr];
                    hcnt_d = HOLD_LD;
                end else begin
                    item_d  = IDLE_VAL;
                    state_d = IDLE;
                end
            end
            default: begin
                item_d  = IDLE_VAL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hcnt   <= '0;
            item_q <= IDLE_VAL;
        end else begin
            state  <= state_d;
            hcnt   <= hcnt_d;
            item_q <= item_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

    assign iface.item = item_q;
    assign busy       = (state != IDLE);
    assign count      = cnt;

endmodule

// File: tb/tb_myiface_producer.sv
// Directed bench for myiface_producer: three instances (HOLD=2, HOLD=3, HOLD=1)
// on a shared clock and reset, outputs sampled 1 time unit after each rising edge.
module tb_myiface_producer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    myiface if2 ();
    myiface if3 ();
    myiface if1 ();

    logic       v2, v3, v1;
    logic [2:0] d2, d3, d1;
    logic       r2, r3, r1;
    logic       b2, b3, b1;
    logic [2:0] c2, c3, c1;

    myiface_producer #(.HOLD(2), .DEPTH(4), .IDLE_VAL(3'b000)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(r2),
        .iface(if2), .busy(b2), .count(c2));
    myiface_producer #(.HOLD(3), .DEPTH(4), .IDLE_VAL(3'b000)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(r3),
        .iface(if3), .busy(b3), .count(c3));
    myiface_producer #(.HOLD(1), .DEPTH(4), .IDLE_VAL(3'b000)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(r1),
        .iface(if1), .busy(b1), .count(c1));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected values after edges 1.. for each scenario
    int b2b_item [7]  = '{1, 1, 2, 2, 3, 3, 0};
    int b2b_cnt  [8]  = '{1, 1, 2, 1, 1, 0, 0, 0};
    int fill_item[20] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5, 6, 6, 6, 0};
    int fill_cnt [20] = '{1, 1, 2, 3, 3, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0};
    int h1_in    [4]  = '{7, 0, 7, 0};
    int h1_item  [6]  = '{0, 7, 0, 7, 0, 0};
    int h1_busy  [6]  = '{0, 1, 1, 1, 1, 0};

    initial begin
        rst_n = 1'b0;
        v2 = 1'b0; v3 = 1'b0; v1 = 1'b0;
        d2 = '0;   d3 = '0;   d1 = '0;
        #2;
        check("rst_item", 32'(if2.item), 0);
        check("rst_busy", 32'(b2), 0);
        check("rst_count", 32'(c2), 0);
        check("rst_ready", 32'(r2), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(r2), 1);

        // single value, HOLD=2
        v2 = 1'b1; d2 = 3'b101;
        step();
        check("single_cnt_e1", 32'(c2), 1);
        check("single_item_e1", 32'(if2.item), 0);
        v2 = 1'b0;
        step();
        check("single_item_e2", 32'(if2.item), 5);
        check("single_busy_e2", 32'(b2), 1);
        step();
        check("single_item_e3", 32'(if2.item), 5);
        check("single_busy_e3", 32'(b2), 1);
        step();
        check("single_item_e4", 32'(if2.item), 0);
        check("single_busy_e4", 32'(b2), 0);

        // back-to-back, HOLD=2
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                v2 = 1'b1; d2 = 3'(i + 1);
            end else begin
                v2 = 1'b0;
            end
            step();
            check("b2b_cnt", 32'(c2), 32'(b2b_cnt[i]));
            if (i >= 1) check("b2b_item", 32'(if2.item), 32'(b2b_item[i-1]));
        end

        // fill, HOLD=3, DEPTH=4; 7 is offered while full and must never be accepted
        for (int i = 0; i < 20; i++) begin
            if (i < 6) begin
                v3 = 1'b1; d3 = 3'(i + 1);
            end else if (i < 8) begin
                v3 = 1'b1; d3 = 3'd7;
            end else begin
                v3 = 1'b0;
            end
            if (i == 5) check("fill_ready_cnt3", 32'(r3), 1);
            if (i == 6 || i == 7) check("fill_ready_full", 32'(r3), 0);
            if (i == 8) check("fill_ready_after_pop", 32'(r3), 1);
            step();
            check("fill_cnt", 32'(c3), 32'(fill_cnt[i]));
            check("fill_item", 32'(if3.item), 32'(fill_item[i]));
        end
        check("fill_busy_end", 32'(b3), 0);

        // HOLD=1 stream
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                v1 = 1'b1; d1 = 3'(h1_in[i]);
            end else begin
                v1 = 1'b0;
            end
            step();
            check("h1_item", 32'(if1.item), 32'(h1_item[i]));
            check("h1_busy", 32'(b1), 32'(h1_busy[i]));
        end

        // reset during second hold cycle with two values queued
        for (int i = 0; i < 3; i++) begin
            v2 = 1'b1; d2 = 3'(i + 1);
            step();
        end
        v2 = 1'b0;
        check("mid_item_pre", 32'(if2.item), 1);
        check("mid_cnt_pre", 32'(c2), 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_item", 32'(if2.item), 0);
        check("mid_rst_cnt", 32'(c2), 0);
        check("mid_rst_busy", 32'(b2), 0);
        check("mid_rst_ready", 32'(r2), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_item", 32'(if2.item), 0);
            check("post_rst_busy", 32'(b2), 0);
            check("post_rst_cnt", 32'(c2), 0);
        end
        v2 = 1'b1; d2 = 3'd6;
        step();
        v2 = 1'b0;
        step();
        check("post_rst_new_item", 32'(if2.item), 6);
        check("post_rst_new_busy", 32'(b2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
